// File: rtl/seven_segment_scan_controller.sv
// Time-multiplexed scan controller for an N-digit seven-segment display.
// Double-buffered content: the shadow is swapped into the active buffer only on frame_done.
module seven_segment_scan_controller #(
  parameter int unsigned w_digit      = 8,
  parameter int unsigned on_cycles    = 1024,
  parameter int unsigned ghost_cycles = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic [4*w_digit-1:0]   number,
  input  logic [w_digit-1:0]     dots,
  input  logic [w_digit-1:0]     blank,
  output logic [7:0]             hgfedcba,
  output logic [w_digit-1:0]     digit,
  output logic                   frame_done
);

  localparam int unsigned OnW  = (on_cycles > 1) ? $clog2(on_cycles) : 1;
  localparam int unsigned GhW  = (ghost_cycles > 1) ? $clog2(ghost_cycles) : 1;
  localparam int unsigned CntW = (OnW > GhW) ? OnW : GhW;
  localparam int unsigned IdxW = (w_digit > 1) ? $clog2(w_digit) : 1;

  localparam logic [CntW-1:0] OnLast  = CntW'(on_cycles - 1);
  localparam logic [CntW-1:0] GhLast  = (ghost_cycles > 0) ? CntW'(ghost_cycles - 1) : '0;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(w_digit - 1);

  typedef enum logic [1:0] {StIdle, StScan, StGhost} state_e;

  state_e                 r_state, w_state_d;
  logic [IdxW-1:0]        r_idx, w_idx_d, w_idx_inc;
  logic [CntW-1:0]        r_cnt, w_cnt_d;

  logic [4*w_digit-1:0]   r_act_number, r_sh_number, w_number_sel;
  logic [w_digit-1:0]     r_act_dots, r_sh_dots, w_dots_sel;
  logic [w_digit-1:0]     r_act_blank, r_sh_blank, w_blank_sel;

  logic                   r_load_ready;
  logic [7:0]             r_hgfedcba, w_hgfedcba_d;
  logic [w_digit-1:0]     r_digit, w_digit_d;
  logic                   r_frame_done, w_frame_done_d;

  logic                   w_accept, w_swap;
  logic [3:0]             w_nibble;
  logic                   w_dot_bit, w_blank_bit;
  logic [6:0]             w_seg;

  assign load_ready = r_load_ready;
  assign hgfedcba   = r_hgfedcba;
  assign digit      = r_digit;
  assign frame_done = r_frame_done;

  assign w_accept = load_valid && r_load_ready;
  // Shadow is full exactly when load_ready is low.
  assign w_swap   = r_frame_done && !r_load_ready;

  // Outputs are registered from the next state, so the first frame cycle sees swapped content.
  assign w_number_sel = w_swap ? r_sh_number : r_act_number;
  assign w_dots_sel   = w_swap ? r_sh_dots   : r_act_dots;
  assign w_blank_sel  = w_swap ? r_sh_blank  : r_act_blank;

  always_comb begin
    w_state_d = r_state;
    w_idx_d   = r_idx;
    w_cnt_d   = r_cnt + 1'b1;
    w_idx_inc = (r_idx == IdxLast) ? '0 : r_idx + 1'b1;
    unique case (r_state)
      StIdle: begin
        w_state_d = StScan;
        w_idx_d   = '0;
        w_cnt_d   = '0;
      end
      StScan: begin
        if (r_cnt == OnLast) begin
          w_cnt_d = '0;
          if (ghost_cycles == 0) w_idx_d = w_idx_inc;
          else w_state_d = StGhost;
        end
      end
      StGhost: begin
        if (r_cnt == GhLast) begin
          w_cnt_d   = '0;
          w_state_d = StScan;
          w_idx_d   = w_idx_inc;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    if (ghost_cycles == 0) begin
      w_frame_done_d = (w_state_d == StScan) && (w_idx_d == IdxLast) && (w_cnt_d == OnLast);
    end else begin
      w_frame_done_d = (w_state_d == StGhost) && (w_idx_d == IdxLast) && (w_cnt_d == GhLast);
    end
  end

  always_comb begin
    w_nibble    = 4'h0;
    w_dot_bit   = 1'b0;
    w_blank_bit = 1'b1;
    for (int unsigned k = 0; k < w_digit; k++) begin
      if (w_idx_d == IdxW'(k)) begin
        w_nibble    = w_number_sel[4*k +: 4];
        w_dot_bit   = w_dots_sel[k];
        w_blank_bit = w_blank_sel[k];
      end
    end
  end

  always_comb begin
    w_seg = 7'h00;
    unique case (w_nibble)
      4'h0: w_seg = 7'h3F;
      4'h1: w_seg = 7'h06;
      4'h2: w_seg = 7'h5B;
      4'h3: w_seg = 7'h4F;
      4'h4: w_seg = 7'h66;
      4'h5: w_seg = 7'h6D;
      4'h6: w_seg = 7'h7D;
      4'h7: w_seg = 7'h07;
      4'h8: w_seg = 7'h7F;
      4'h9: w_seg = 7'h6F;
      4'hA: w_seg = 7'h77;
      4'hB: w_seg = 7'h7C;
      4'hC: w_seg = 7'h39;
      4'hD: w_seg = 7'h5E;
      4'hE: w_seg = 7'h79;
      4'hF: w_seg = 7'h71;
      default: w_seg = 7'h00;
    endcase
  end

  always_comb begin
    w_digit_d    = '0;
    w_hgfedcba_d = 8'h00;
    if (w_state_d == StScan) begin
      w_digit_d = {{(w_digit-1){1'b0}}, 1'b1} << w_idx_d;
      if (!w_blank_bit) w_hgfedcba_d = {w_dot_bit, w_seg};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_digit      <= '0;
      r_hgfedcba   <= 8'h00;
      r_frame_done <= 1'b0;
      r_load_ready <= 1'b1;
      r_act_number <= '0;
      r_act_dots   <= '0;
      r_act_blank  <= '1;
      r_sh_number  <= '0;
      r_sh_dots    <= '0;
      r_sh_blank   <= '0;
    end else begin
      r_state      <= w_state_d;
      r_idx        <= w_idx_d;
      r_cnt        <= w_cnt_d;
      r_digit      <= w_digit_d;
      r_hgfedcba   <= w_hgfedcba_d;
      r_frame_done <= w_frame_done_d;
      if (w_swap) begin
        r_act_number <= r_sh_number;
        r_act_dots   <= r_sh_dots;
        r_act_blank  <= r_sh_blank;
      end
      if (w_accept) begin
        r_sh_number <= number;
        r_sh_dots   <= dots;
        r_sh_blank  <= blank;
      end
      if (w_accept) r_load_ready <= 1'b0;
      else if (w_swap) r_load_ready <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// Directed bench: 4 digits, 4 on-cycles, 2 ghost cycles, plus a ghost-free build checked alongside.
module tb_seven_segment_scan_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_valid = 1'b0;
  logic [15:0] number = 16'h0;
  logic [3:0]  dots = 4'h0;
  logic [3:0]  blank = 4'h0;
  logic        load_ready;
  logic [7:0]  hgfedcba;
  logic [3:0]  digit;
  logic        frame_done;

  logic        load_ready2;
  logic [7:0]  hgfedcba2;
  logic [3:0]  digit2;
  logic        frame_done2;

  int total = 0;
  int bad = 0;
  int p = -1;
  bit chk_en = 1'b0;

  logic [15:0] e_num = 16'h0;
  logic [3:0]  e_dots = 4'h0;
  logic [3:0]  e_blank = 4'hF;

  seven_segment_scan_controller #(
    .w_digit(4), .on_cycles(4), .ghost_cycles(2)
  ) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .number(number), .dots(dots), .blank(blank),
    .hgfedcba(hgfedcba), .digit(digit), .frame_done(frame_done)
  );

  seven_segment_scan_controller #(
    .w_digit(4), .on_cycles(4), .ghost_cycles(0)
  ) dut_ng (
    .clk(clk), .rst(rst), .load_valid(1'b0), .load_ready(load_ready2),
    .number(16'h0000), .dots(4'h0), .blank(4'h0),
    .hgfedcba(hgfedcba2), .digit(digit2), .frame_done(frame_done2)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  function automatic logic [7:0] exp_seg(input int idx);
    if (e_blank[idx]) return 8'h00;
    return {e_dots[idx], seg7(e_num[4*idx +: 4])};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s p=%0d got=%0h want=%0h", tag, p, obs, want);
    end
  endtask

  task automatic step();
    int slot;
    int idx;
    int idx2;
    @(posedge clk);
    #1;
    p++;
    if (chk_en) begin
      slot = p % 6;
      idx  = (p % 24) / 6;
      idx2 = (p % 16) / 4;
      chk("digit", 32'(digit), (slot < 4) ? (32'd1 << idx) : 32'd0);
      chk("seg", 32'(hgfedcba), (slot < 4) ? 32'(exp_seg(idx)) : 32'd0);
      chk("frame_done", 32'(frame_done), 32'((p % 24) == 23));
      chk("ng_digit", 32'(digit2), 32'd1 << idx2);
      chk("ng_seg", 32'(hgfedcba2), 32'd0);
      chk("ng_frame_done", 32'(frame_done2), 32'((p % 16) == 15));
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_digit", 32'(digit), 32'd0);
    chk("rst_seg", 32'(hgfedcba), 32'd0);
    chk("rst_ready", 32'(load_ready), 32'd1);
    chk("rst_fd", 32'(frame_done), 32'd0);
    chk("rst_ng_digit", 32'(digit2), 32'd0);
    rst = 1'b0;
    p = -1;
    chk_en = 1'b1;

    // Idle: two all-blank frames, then start of the third.
    repeat (49) step();

    // Load 12AF with dot on digit 2 at the start of frame 3.
    load_valid = 1'b1;
    number = 16'h12AF;
    dots = 4'b0100;
    blank = 4'b0000;
    step();
    chk("ready_after_load", 32'(load_ready), 32'd0);

    // Keep valid high with new data while the shadow is full.
    number = 16'h0000;
    dots = 4'b0000;
    while (p < 71) step();
    chk("ready_before_swap", 32'(load_ready), 32'd0);
    e_num = 16'h12AF;
    e_dots = 4'b0100;
    e_blank = 4'b0000;
    step();
    chk("ready_after_swap", 32'(load_ready), 32'd1);
    step();
    chk("ready_held_capture", 32'(load_ready), 32'd0);
    load_valid = 1'b0;
    while (p < 95) step();
    e_num = 16'h0000;
    e_dots = 4'b0000;

    // Load on the exact frame_done cycle: not swapped until the following frame.
    while (p < 119) step();
    chk("ready_on_fd", 32'(load_ready), 32'd1);
    load_valid = 1'b1;
    number = 16'h8888;
    step();
    chk("ready_after_fd_load", 32'(load_ready), 32'd0);
    load_valid = 1'b0;
    while (p < 143) step();
    e_num = 16'h8888;
    step();
    chk("ready_after_late_swap", 32'(load_ready), 32'd1);

    // Leave content pending in the shadow, then reset during SCAN(2).
    load_valid = 1'b1;
    number = 16'h3456;
    dots = 4'hF;
    step();
    chk("ready_pending", 32'(load_ready), 32'd0);
    load_valid = 1'b0;
    while (p < 157) step();
    rst = 1'b1;
    chk_en = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_digit", 32'(digit), 32'd0);
    chk("midrst_seg", 32'(hgfedcba), 32'd0);
    chk("midrst_ready", 32'(load_ready), 32'd1);
    chk("midrst_fd", 32'(frame_done), 32'd0);
    chk("midrst_ng_digit", 32'(digit2), 32'd0);
    rst = 1'b0;
    p = -1;
    e_num = 16'h0000;
    e_dots = 4'h0;
    e_blank = 4'hF;
    chk_en = 1'b1;
    // Two frames blank: pending 3456 must never appear.
    repeat (48) step();
    chk("ready_after_restart", 32'(load_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
